// File: rtl/bp_cce_hybrid_uc_resp_pipe_pkg.sv
// bp_cce_hybrid_uc_resp_pipe_pkg: configuration constants, BedRock message enums/headers and the stream beat-count helper
package bp_cce_hybrid_uc_resp_pipe_pkg;

   localparam int paddr_width_p     = 40;
   localparam int lce_id_width_p    = 4;
   localparam int cce_id_width_p    = 4;
   localparam int lce_assoc_p       = 8;
   localparam int way_id_width_lp   = $clog2(lce_assoc_p);
   localparam int cce_block_width_p = 512;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bp_bedrock_msg_size_e;

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   typedef enum logic [3:0] {
      e_bedrock_cmd_sync       = 4'd0,
      e_bedrock_cmd_set_clear  = 4'd1,
      e_bedrock_cmd_inv        = 4'd2,
      e_bedrock_cmd_st         = 4'd3,
      e_bedrock_cmd_data       = 4'd4,
      e_bedrock_cmd_st_wakeup  = 4'd5,
      e_bedrock_cmd_wb         = 4'd6,
      e_bedrock_cmd_set_tag    = 4'd7,
      e_bedrock_cmd_st_tr      = 4'd8,
      e_bedrock_cmd_st_wb      = 4'd9,
      e_bedrock_cmd_tr         = 4'd10,
      e_bedrock_cmd_st_tr_wb   = 4'd11,
      e_bedrock_cmd_uc_data    = 4'd12,
      e_bedrock_cmd_uc_st_done = 4'd13
   } bp_bedrock_cmd_type_e;

   typedef enum logic [2:0] {
      e_COH_I = 3'd0,
      e_COH_S = 3'd1,
      e_COH_E = 3'd2,
      e_COH_F = 3'd3,
      e_COH_O = 3'd4,
      e_COH_M = 3'd5
   } bp_coh_states_e;

   typedef struct packed {
      bp_coh_states_e              state;
      logic [way_id_width_lp-1:0]  way_id;
      logic [lce_id_width_p-1:0]   lce_id;
      logic                        uncached;
   } bp_bedrock_mem_payload_s;

   typedef struct packed {
      bp_bedrock_mem_type_e        msg_type;
      logic [paddr_width_p-1:0]    addr;
      bp_bedrock_msg_size_e        size;
      bp_bedrock_mem_payload_s     payload;
   } bp_bedrock_mem_header_s;

   typedef struct packed {
      logic [lce_id_width_p-1:0]   dst_id;
      logic [cce_id_width_p-1:0]   src_id;
      logic [way_id_width_lp-1:0]  way_id;
      bp_coh_states_e              state;
   } bp_bedrock_lce_cmd_payload_s;

   typedef struct packed {
      bp_bedrock_cmd_type_e        msg_type;
      logic [paddr_width_p-1:0]    addr;
      bp_bedrock_msg_size_e        size;
      bp_bedrock_lce_cmd_payload_s payload;
   } bp_bedrock_lce_cmd_header_s;

   typedef enum logic [1:0] {e_header, e_data, e_drain} bp_cce_uc_resp_state_e;

   // Number of beats a stream message of the given size occupies; sub-beat messages still take one beat.
   function automatic int bp_me_stream_beats(input bp_bedrock_msg_size_e size, input int width);
      int beats;
      beats = (32'sd1 <<< size) / (width / 8);
      return (beats < 1) ? 1 : beats;
   endfunction

endpackage

// File: rtl/bp_cce_hybrid_uc_resp_pipe_fifo.sv
// bp_cce_hybrid_uc_resp_pipe_fifo: small 1R1W ready/valid FIFO; ready_o is ~full, data_o/v_o show the head, yumi_i pops it.
//   clk_i/reset_i : clock, async active-high reset (clears pointers and count)
//   data_i/v_i/ready_o : enqueue side
//   data_o/v_o/yumi_i  : dequeue side
module bp_cce_hybrid_uc_resp_pipe_fifo #(
   parameter int width_p = 1,
   parameter int els_p   = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);
   localparam int ptr_width_lp = $clog2(els_p);
   localparam int cnt_width_lp = $clog2(els_p + 1);
   logic [width_p-1:0]      mem_q [els_p];
   logic [ptr_width_lp-1:0] rptr_q, wptr_q;
   logic [cnt_width_lp-1:0] cnt_q;
   logic                    enq;
   function automatic logic [ptr_width_lp-1:0] inc(input logic [ptr_width_lp-1:0] p);
      return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
   endfunction
   assign ready_o = cnt_q != cnt_width_lp'(els_p);
   assign v_o     = cnt_q != '0;
   assign data_o  = mem_q[rptr_q];
   assign enq     = v_i & ready_o;
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (enq) wptr_q <= inc(wptr_q);
         if (yumi_i) rptr_q <= inc(rptr_q);
         cnt_q <= cnt_q + cnt_width_lp'(enq) - cnt_width_lp'(yumi_i);
      end
   end
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wptr_q] <= data_i;
   end
   a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
endmodule

// File: rtl/bp_cce_hybrid_uc_resp_pipe.sv
// bp_cce_hybrid_uc_resp_pipe: converts uncached/non-coherent memory stream responses into LCE burst commands.
//   clk_i/reset_i        : clock, async active-high reset (FSM, beat counter, FIFO)
//   cce_id_i             : source id written into every command header
//   mem_resp_*           : stream input (header repeated per beat, data, last, v/ready_and)
//   lce_cmd_header_*     : burst header out, has_data tells whether data beats follow
//   lce_cmd_data_*       : burst data beats out with last
//   empty_o              : no message buffered or in flight
module bp_cce_hybrid_uc_resp_pipe
   import bp_cce_hybrid_uc_resp_pipe_pkg::*;
#(
   parameter  int lce_data_width_p    = 64,
   parameter  int mem_data_width_p    = 64,
   parameter  int mem_resp_fifo_els_p = 2,
   localparam int mem_hdr_width_lp    = $bits(bp_bedrock_mem_header_s),
   localparam int cmd_hdr_width_lp    = $bits(bp_bedrock_lce_cmd_header_s)
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [cce_id_width_p-1:0]   cce_id_i,
   input  logic [mem_hdr_width_lp-1:0] mem_resp_header_i,
   input  logic [mem_data_width_p-1:0] mem_resp_data_i,
   input  logic                        mem_resp_v_i,
   output logic                        mem_resp_ready_and_o,
   input  logic                        mem_resp_last_i,
   output logic [cmd_hdr_width_lp-1:0] lce_cmd_header_o,
   output logic                        lce_cmd_header_v_o,
   input  logic                        lce_cmd_header_ready_and_i,
   output logic                        lce_cmd_has_data_o,
   output logic [lce_data_width_p-1:0] lce_cmd_data_o,
   output logic                        lce_cmd_data_v_o,
   input  logic                        lce_cmd_data_ready_and_i,
   output logic                        lce_cmd_last_o,
   output logic                        empty_o
);
   localparam int cnt_width_lp  = $clog2(cce_block_width_p / mem_data_width_p) + 1;
   localparam int fifo_width_lp = 1 + mem_hdr_width_lp + mem_data_width_p;

   if (mem_data_width_p != lce_data_width_p) begin : g_width_chk
      $fatal(1, "mem_data_width_p must equal lce_data_width_p");
   end
   if (mem_resp_fifo_els_p < 2) begin : g_els_chk
      $fatal(1, "mem_resp_fifo_els_p must be at least 2");
   end

   logic                       fifo_v, fifo_yumi, fifo_last;
   logic [fifo_width_lp-1:0]   fifo_data;
   bp_bedrock_mem_header_s     mem_hdr;
   logic [mem_data_width_p-1:0] mem_data;
   bp_bedrock_lce_cmd_header_s cmd_hdr;
   bp_cce_uc_resp_state_e      state_q, state_d;
   logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
   logic                       is_uc_rd, is_uc_wr, is_amo, fill, legal, hdr_hs, data_hs;

   bp_cce_hybrid_uc_resp_pipe_fifo #(
      .width_p (fifo_width_lp),
      .els_p   (mem_resp_fifo_els_p)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  ({mem_resp_last_i, mem_resp_header_i, mem_resp_data_i}),
      .v_i     (mem_resp_v_i),
      .ready_o (mem_resp_ready_and_o),
      .v_o     (fifo_v),
      .data_o  (fifo_data),
      .yumi_i  (fifo_yumi)
   );

   assign {fifo_last, mem_hdr, mem_data} = fifo_data;

   assign is_uc_rd = mem_hdr.msg_type == e_bedrock_mem_uc_rd;
   assign is_uc_wr = mem_hdr.msg_type == e_bedrock_mem_uc_wr;
   assign is_amo   = mem_hdr.msg_type == e_bedrock_mem_amo;
   // A cacheable uc_rd is a block fill and must carry the coherence state back to the LCE.
   assign fill     = is_uc_rd & ~mem_hdr.payload.uncached;
   assign legal    = is_uc_rd | is_uc_wr | is_amo;

   always_comb begin
      cmd_hdr                = '0;
      cmd_hdr.msg_type       = is_uc_wr ? e_bedrock_cmd_uc_st_done : fill ? e_bedrock_cmd_data : e_bedrock_cmd_uc_data;
      cmd_hdr.addr           = mem_hdr.addr;
      cmd_hdr.size           = mem_hdr.size;
      cmd_hdr.payload.dst_id = mem_hdr.payload.lce_id;
      cmd_hdr.payload.src_id = cce_id_i;
      cmd_hdr.payload.way_id = mem_hdr.payload.way_id;
      cmd_hdr.payload.state  = fill ? mem_hdr.payload.state : e_COH_I;
   end

   assign lce_cmd_header_o   = cmd_hdr;
   assign lce_cmd_has_data_o = is_uc_rd | is_amo;
   assign lce_cmd_header_v_o = (state_q == e_header) & fifo_v & legal;
   assign lce_cmd_data_v_o   = (state_q == e_data) & fifo_v;
   assign lce_cmd_data_o     = mem_data;
   assign lce_cmd_last_o     = fifo_last;
   assign hdr_hs             = lce_cmd_header_v_o & lce_cmd_header_ready_and_i;
   assign data_hs            = lce_cmd_data_v_o & lce_cmd_data_ready_and_i;
   assign empty_o            = (state_q == e_header) & ~fifo_v;

   // The header beat of a data message stays in the FIFO so its data is sent as the first burst beat.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fifo_yumi = 1'b0;
      case (state_q)
         e_header: begin
            if (fifo_v & ~legal) state_d = e_drain;
            else if (hdr_hs & lce_cmd_has_data_o) begin
               state_d = e_data;
               cnt_d   = '0;
            end else fifo_yumi = hdr_hs;
         end
         e_data: begin
            fifo_yumi = data_hs;
            if (data_hs) cnt_d = cnt_q + 1'b1;
            if (data_hs & fifo_last) state_d = e_header;
         end
         e_drain: begin
            fifo_yumi = fifo_v;
            if (fifo_v & fifo_last) state_d = e_header;
         end
         default: state_d = e_header;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= e_header;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   a_legal_type: assert property (@(posedge clk_i) disable iff (reset_i)
      !((state_q == e_header) && fifo_v && !legal));
   a_nodata_last: assert property (@(posedge clk_i) disable iff (reset_i)
      (hdr_hs && !lce_cmd_has_data_o) |-> fifo_last);
   a_beat_count: assert property (@(posedge clk_i) disable iff (reset_i)
      data_hs |-> (fifo_last == ((int'(cnt_q) + 1) == bp_me_stream_beats(mem_hdr.size, mem_data_width_p))));
endmodule

// File: tb/tb_bp_cce_hybrid_uc_resp_pipe.sv
// tb_bp_cce_hybrid_uc_resp_pipe: directed self-checking bench for the uncached response pipe
module tb_bp_cce_hybrid_uc_resp_pipe;
   import bp_cce_hybrid_uc_resp_pipe_pkg::*;

   logic                       clk_i = 1'b0;
   logic                       reset_i = 1'b1;
   logic [cce_id_width_p-1:0]  cce_id_i = 4'd2;
   bp_bedrock_mem_header_s     mem_resp_header_i = '0;
   logic [63:0]                mem_resp_data_i = '0;
   logic                       mem_resp_v_i = 1'b0;
   logic                       mem_resp_ready_and_o;
   logic                       mem_resp_last_i = 1'b0;
   bp_bedrock_lce_cmd_header_s lce_cmd_header_o;
   logic                       lce_cmd_header_v_o;
   logic                       lce_cmd_header_ready_and_i = 1'b1;
   logic                       lce_cmd_has_data_o;
   logic [63:0]                lce_cmd_data_o;
   logic                       lce_cmd_data_v_o;
   logic                       lce_cmd_data_ready_and_i = 1'b1;
   logic                       lce_cmd_last_o;
   logic                       empty_o;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic tog = 1'b0;
   logic saw_full = 1'b0;
   logic stall_q = 1'b0;
   logic stall_l = 1'b0;
   logic [63:0] stall_d = '0;

   typedef struct {bp_bedrock_lce_cmd_header_s h; logic hd; int c;} hrec_t;
   typedef struct {logic [63:0] d; logic l; int c;} drec_t;
   hrec_t hq[$];
   drec_t dq[$];

   bp_cce_hybrid_uc_resp_pipe dut (
      .clk_i                      (clk_i),
      .reset_i                    (reset_i),
      .cce_id_i                   (cce_id_i),
      .mem_resp_header_i          (mem_resp_header_i),
      .mem_resp_data_i            (mem_resp_data_i),
      .mem_resp_v_i               (mem_resp_v_i),
      .mem_resp_ready_and_o       (mem_resp_ready_and_o),
      .mem_resp_last_i            (mem_resp_last_i),
      .lce_cmd_header_o           (lce_cmd_header_o),
      .lce_cmd_header_v_o         (lce_cmd_header_v_o),
      .lce_cmd_header_ready_and_i (lce_cmd_header_ready_and_i),
      .lce_cmd_has_data_o         (lce_cmd_has_data_o),
      .lce_cmd_data_o             (lce_cmd_data_o),
      .lce_cmd_data_v_o           (lce_cmd_data_v_o),
      .lce_cmd_data_ready_and_i   (lce_cmd_data_ready_and_i),
      .lce_cmd_last_o             (lce_cmd_last_o),
      .empty_o                    (empty_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: decisions taken at the falling edge complete on the following rising edge.
   always @(negedge clk_i) begin
      if (reset_i) stall_q = 1'b0;
      else begin
         lce_cmd_data_ready_and_i = tog ? ~lce_cmd_data_ready_and_i : 1'b1;
         if (stall_q) begin
            chk("stall.v", lce_cmd_data_v_o, 1'b1);
            chk("stall.d", lce_cmd_data_o, stall_d);
            chk("stall.l", lce_cmd_last_o, stall_l);
         end
         if (lce_cmd_header_v_o & lce_cmd_header_ready_and_i) hq.push_back('{lce_cmd_header_o, lce_cmd_has_data_o, cyc});
         if (lce_cmd_data_v_o & lce_cmd_data_ready_and_i) dq.push_back('{lce_cmd_data_o, lce_cmd_last_o, cyc});
         stall_q = lce_cmd_data_v_o & ~lce_cmd_data_ready_and_i;
         stall_d = lce_cmd_data_o;
         stall_l = lce_cmd_last_o;
         if (!mem_resp_ready_and_o) saw_full = 1'b1;
      end
   end

   function automatic bp_bedrock_mem_header_s mh(input bp_bedrock_mem_type_e t, input bp_bedrock_msg_size_e s,
                                                 input logic [39:0] a, input logic [3:0] lce, input logic [2:0] way,
                                                 input bp_coh_states_e st, input logic unc);
      mh                  = '0;
      mh.msg_type         = t;
      mh.size             = s;
      mh.addr             = a;
      mh.payload.lce_id   = lce;
      mh.payload.way_id   = way;
      mh.payload.state    = st;
      mh.payload.uncached = unc;
   endfunction

   task automatic send(input bp_bedrock_mem_header_s h, input logic [63:0] d, input logic l);
      logic acc = 1'b0;
      mem_resp_header_i = h;
      mem_resp_data_i   = d;
      mem_resp_last_i   = l;
      mem_resp_v_i      = 1'b1;
      for (int n = 0; n < 50 && !acc; n++) begin
         acc = mem_resp_ready_and_o;
         @(negedge clk_i);
      end
      chk("send.accepted", acc, 1'b1);
      mem_resp_v_i = 1'b0;
   endtask

   task automatic wait_out(input string tag, input int nh, input int nd);
      int n = 0;
      while ((hq.size() < nh || dq.size() < nd) && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      repeat (3) @(negedge clk_i);
      chk({tag, ".nhdr"}, hq.size(), nh);
      chk({tag, ".ndata"}, dq.size(), nd);
      chk({tag, ".empty"}, empty_o, 1'b1);
   endtask

   task automatic chk_hdr(input string tag, input hrec_t r, input bp_bedrock_cmd_type_e t, input logic [39:0] a,
                          input bp_bedrock_msg_size_e s, input logic [3:0] dst, input logic [2:0] way,
                          input bp_coh_states_e st, input logic hd);
      chk({tag, ".type"}, r.h.msg_type, t);
      chk({tag, ".addr"}, r.h.addr, a);
      chk({tag, ".size"}, r.h.size, s);
      chk({tag, ".dst"}, r.h.payload.dst_id, dst);
      chk({tag, ".src"}, r.h.payload.src_id, 4'd2);
      chk({tag, ".way"}, r.h.payload.way_id, way);
      chk({tag, ".state"}, r.h.payload.state, st);
      chk({tag, ".has_data"}, r.hd, hd);
   endtask

   task automatic run_fill(input string tag, input logic t);
      tog = t;
      saw_full = 1'b0;
      for (int i = 0; i < 8; i++)
         send(mh(e_bedrock_mem_uc_rd, e_bedrock_msg_size_64, 40'h8040, 4'd6, 3'd5, e_COH_M, 1'b0), 64'(i), i == 7);
      wait_out(tag, 1, 8);
      tog = 1'b0;
      if (hq.size() == 1) chk_hdr(tag, hq[0], e_bedrock_cmd_data, 40'h8040, e_bedrock_msg_size_64, 4'd6, 3'd5, e_COH_M, 1'b1);
      for (int i = 0; i < 8 && i < dq.size(); i++) begin
         chk({tag, ".beat"}, dq[i].d, 64'(i));
         chk({tag, ".last"}, dq[i].l, i == 7);
      end
      chk({tag, ".ready_dropped"}, saw_full, 1'b1);
      hq.delete();
      dq.delete();
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      chk("rst.hdr_v", lce_cmd_header_v_o, 1'b0);
      chk("rst.data_v", lce_cmd_data_v_o, 1'b0);
      chk("rst.empty", empty_o, 1'b1);
      reset_i = 1'b0;
      @(negedge clk_i);

      send(mh(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h1000, 4'd3, 3'd1, e_COH_I, 1'b1), 64'h0, 1'b1);
      wait_out("wr", 1, 0);
      if (hq.size() == 1) chk_hdr("wr", hq[0], e_bedrock_cmd_uc_st_done, 40'h1000, e_bedrock_msg_size_8, 4'd3, 3'd1, e_COH_I, 1'b0);
      hq.delete();
      dq.delete();

      send(mh(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, 40'h2008, 4'd1, 3'd2, e_COH_S, 1'b1), 64'hDEADBEEF_CAFEF00D, 1'b1);
      wait_out("ucrd", 1, 1);
      if (hq.size() == 1) chk_hdr("ucrd", hq[0], e_bedrock_cmd_uc_data, 40'h2008, e_bedrock_msg_size_8, 4'd1, 3'd2, e_COH_I, 1'b1);
      if (dq.size() == 1) begin
         chk("ucrd.beat", dq[0].d, 64'hDEADBEEF_CAFEF00D);
         chk("ucrd.last", dq[0].l, 1'b1);
      end
      hq.delete();
      dq.delete();

      run_fill("fill", 1'b0);
      run_fill("fill_bp", 1'b1);

      send(mh(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h3000, 4'd2, 3'd0, e_COH_I, 1'b1), 64'h0, 1'b1);
      send(mh(e_bedrock_mem_amo, e_bedrock_msg_size_8, 40'h3008, 4'd2, 3'd4, e_COH_I, 1'b1), 64'h55AA, 1'b1);
      wait_out("b2b", 2, 1);
      if (hq.size() == 2 && dq.size() == 1) begin
         chk_hdr("b2b.0", hq[0], e_bedrock_cmd_uc_st_done, 40'h3000, e_bedrock_msg_size_8, 4'd2, 3'd0, e_COH_I, 1'b0);
         chk_hdr("b2b.1", hq[1], e_bedrock_cmd_uc_data, 40'h3008, e_bedrock_msg_size_8, 4'd2, 3'd4, e_COH_I, 1'b1);
         chk("b2b.beat", dq[0].d, 64'h55AA);
         chk("b2b.last", dq[0].l, 1'b1);
         chk("b2b.gap_ok", (hq[1].c - hq[0].c) <= 2, 1'b1);
         chk("b2b.order", dq[0].c > hq[1].c, 1'b1);
      end
      hq.delete();
      dq.delete();

      for (int i = 0; i < 4; i++)
         send(mh(e_bedrock_mem_uc_rd, e_bedrock_msg_size_64, 40'h9000, 4'd4, 3'd6, e_COH_E, 1'b0), 64'h100 + 64'(i), 1'b0);
      @(posedge clk_i);
      #2 reset_i = 1'b1;
      #1;
      chk("arst.hdr_v", lce_cmd_header_v_o, 1'b0);
      chk("arst.data_v", lce_cmd_data_v_o, 1'b0);
      chk("arst.empty", empty_o, 1'b1);
      hq.delete();
      dq.delete();
      @(negedge clk_i);
      reset_i = 1'b0;
      repeat (4) @(negedge clk_i);
      chk("arst.no_hdr", hq.size(), 0);
      chk("arst.no_data", dq.size(), 0);
      chk("arst.empty_after", empty_o, 1'b1);

      send(mh(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, 40'h4010, 4'd7, 3'd3, e_COH_I, 1'b1), 64'h01234567_89ABCDEF, 1'b1);
      wait_out("post", 1, 1);
      if (hq.size() == 1) chk_hdr("post", hq[0], e_bedrock_cmd_uc_data, 40'h4010, e_bedrock_msg_size_8, 4'd7, 3'd3, e_COH_I, 1'b1);
      if (dq.size() == 1) begin
         chk("post.beat", dq[0].d, 64'h01234567_89ABCDEF);
         chk("post.last", dq[0].l, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
